// File: rtl/pe_dbuf_if.sv
// Port bundle for one systolic PE: operand/partial-sum inputs, weight chain and strobes.
// master drives the PE inputs; slave is the PE itself.
interface pe_dbuf_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
);
    logic                     active_in;
    logic signed [DATA_W-1:0] data_in;
    logic signed [SUM_W-1:0]  sum_in;
    logic                     acc_mode;
    logic signed [DATA_W-1:0] w_in;
    logic                     wload_in;
    logic                     wswap_in;

    logic signed [DATA_W-1:0] data_out;
    logic signed [SUM_W-1:0]  sum_out;
    logic signed [DATA_W-1:0] w_out;
    logic                     wload_out;
    logic                     wswap_out;
    logic                     active_out;
    logic                     ovf_out;

    modport master (
        output active_in, data_in, sum_in, acc_mode, w_in, wload_in, wswap_in,
        input  data_out, sum_out, w_out, wload_out, wswap_out, active_out, ovf_out
    );

    modport slave (
        input  active_in, data_in, sum_in, acc_mode, w_in, wload_in, wswap_in,
        output data_out, sum_out, w_out, wload_out, wswap_out, active_out, ovf_out
    );
endinterface

// File: rtl/pe_dbuf.sv
// Systolic processing element with double-buffered weights: a shadow weight shifts
// along a chain while the active weight feeds a saturating/wrapping multiply-accumulate.
module pe_dbuf #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input logic      clk,
    input logic      reset,
    pe_dbuf_if.slave pe
);
    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    logic signed [DATA_W-1:0]   wsh;
    logic signed [DATA_W-1:0]   wact;
    logic signed [SUM_W-1:0]    addend;
    logic signed [2*DATA_W-1:0] product;
    logic signed [SUM_W:0]      sum_full;
    logic signed [SUM_W-1:0]    sum_next;
    logic                       ovf;

    // One guard bit above SUM_W is enough: addend and product both fit in SUM_W.
    always_comb begin
        addend   = pe.acc_mode ? pe.sum_out : pe.sum_in;
        product  = (2*DATA_W)'(pe.data_in) * (2*DATA_W)'(wact);
        sum_full = (SUM_W+1)'(addend) + (SUM_W+1)'(product);
        ovf      = sum_full[SUM_W] ^ sum_full[SUM_W-1];
        sum_next = sum_full[SUM_W-1:0];
        if (ovf && SAT_EN) begin
            sum_next = sum_full[SUM_W] ? SUM_MIN : SUM_MAX;
        end
    end

    // The weight chain and strobes run every cycle, independent of active_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wsh           <= '0;
            wact          <= '0;
            pe.w_out      <= '0;
            pe.wload_out  <= 1'b0;
            pe.wswap_out  <= 1'b0;
            pe.active_out <= 1'b0;
        end else begin
            pe.wload_out  <= pe.wload_in;
            pe.wswap_out  <= pe.wswap_in;
            pe.active_out <= pe.active_in;
            pe.w_out      <= pe.wload_in ? wsh : '0;
            if (pe.wload_in) begin
                wsh <= pe.w_in;
            end
            if (pe.wswap_in) begin
                wact <= wsh;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe.data_out <= '0;
            pe.sum_out  <= '0;
            pe.ovf_out  <= 1'b0;
        end else if (pe.active_in) begin
            pe.data_out <= pe.data_in;
            pe.sum_out  <= sum_next;
            if (ovf) begin
                pe.ovf_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_dbuf.sv
// Scoreboard bench: a saturating and a wrapping PE get identical stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_pe_dbuf;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 16;
    localparam int SMAX   = 2**(SUM_W-1) - 1;
    localparam int SMIN   = -(2**(SUM_W-1));
    localparam int SPAN   = 2**SUM_W;

    typedef struct {
        bit active;
        int data;
        int sum_in;
        bit acc;
        int w;
        bit wload;
        bit wswap;
    } stim_t;

    typedef struct {
        int data_out;
        int sum_sat;
        int sum_wrap;
        int w_out;
        bit ovf_sat;
        bit ovf_wrap;
        bit wload;
        bit wswap;
        bit active;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t m_out;
    exp_t mon_e;
    int   m_wsh;
    int   m_wact;

    always #5 clk = ~clk;

    pe_dbuf_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus_sat ();
    pe_dbuf_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus_wrap ();

    pe_dbuf #(.DATA_W(DATA_W), .SUM_W(SUM_W), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .pe(bus_sat)
    );
    pe_dbuf #(.DATA_W(DATA_W), .SUM_W(SUM_W), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .pe(bus_wrap)
    );

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input bit active, input int data, input int sum_in,
                                 input bit acc, input int w, input bit wload, input bit wswap);
        stim_t s;
        s.active = active; s.data = data; s.sum_in = sum_in; s.acc = acc;
        s.w = w; s.wload = wload; s.wswap = wswap;
        return s;
    endfunction

    function automatic void modelReset();
        m_out = '{default: 0};
        m_wsh = 0;
        m_wact = 0;
    endfunction

    // Reference behaviour: plain integer arithmetic on the pre-edge state.
    function automatic void modelStep(input stim_t s);
        int full;
        if (s.active) begin
            m_out.data_out = s.data;
            full = (s.acc ? m_out.sum_sat : s.sum_in) + s.data * m_wact;
            if (full > SMAX || full < SMIN) m_out.ovf_sat = 1'b1;
            m_out.sum_sat = (full > SMAX) ? SMAX : (full < SMIN) ? SMIN : full;
            full = (s.acc ? m_out.sum_wrap : s.sum_in) + s.data * m_wact;
            if (full > SMAX || full < SMIN) m_out.ovf_wrap = 1'b1;
            m_out.sum_wrap = (full > SMAX) ? full - SPAN : (full < SMIN) ? full + SPAN : full;
        end
        m_out.w_out  = s.wload ? m_wsh : 0;
        if (s.wswap) m_wact = m_wsh;
        if (s.wload) m_wsh = s.w;
        m_out.wload  = s.wload;
        m_out.wswap  = s.wswap;
        m_out.active = s.active;
    endfunction

    task automatic driveBus(input stim_t s);
        bus_sat.active_in  = s.active;
        bus_sat.data_in    = DATA_W'(s.data);
        bus_sat.sum_in     = SUM_W'(s.sum_in);
        bus_sat.acc_mode   = s.acc;
        bus_sat.w_in       = DATA_W'(s.w);
        bus_sat.wload_in   = s.wload;
        bus_sat.wswap_in   = s.wswap;
        bus_wrap.active_in = s.active;
        bus_wrap.data_in   = DATA_W'(s.data);
        bus_wrap.sum_in    = SUM_W'(s.sum_in);
        bus_wrap.acc_mode  = s.acc;
        bus_wrap.w_in      = DATA_W'(s.w);
        bus_wrap.wload_in  = s.wload;
        bus_wrap.wswap_in  = s.wswap;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveBus(s);
        modelStep(s);
        exp_q.push_back(m_out);
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("data_out", bus_sat.data_out, e.data_out);
        checkField("sum_out_sat", bus_sat.sum_out, e.sum_sat);
        checkField("ovf_out_sat", bus_sat.ovf_out, e.ovf_sat);
        checkField("w_out", bus_sat.w_out, e.w_out);
        checkField("wload_out", bus_sat.wload_out, e.wload);
        checkField("wswap_out", bus_sat.wswap_out, e.wswap);
        checkField("active_out", bus_sat.active_out, e.active);
        checkField("data_out_wrap", bus_wrap.data_out, e.data_out);
        checkField("sum_out_wrap", bus_wrap.sum_out, e.sum_wrap);
        checkField("ovf_out_wrap", bus_wrap.ovf_out, e.ovf_wrap);
        checkField("w_out_wrap", bus_wrap.w_out, e.w_out);
    endtask

    task automatic checkZero();
        checkField("rst_data_out", bus_sat.data_out, 0);
        checkField("rst_sum_out", bus_sat.sum_out, 0);
        checkField("rst_w_out", bus_sat.w_out, 0);
        checkField("rst_ovf_out", bus_sat.ovf_out, 0);
        checkField("rst_strobes", {bus_sat.wload_out, bus_sat.wswap_out, bus_sat.active_out}, 0);
        checkField("rst_sum_out_wrap", bus_wrap.sum_out, 0);
        checkField("rst_ovf_out_wrap", bus_wrap.ovf_out, 0);
    endtask

    // Reset lands between edges, after the monitor has consumed the last result.
    task automatic resetPulse();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkZero();
        reset = 1'b0;
        modelReset();
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        modelReset();
        driveBus(mk(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #3;
        checkZero();
        reset = 1'b0;

        // Two-step chain load then swap.
        applyStimulus(mk(0, 0, 0, 0, 5, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 7, 1, 0));
        settle(); checkField("load_w_out", bus_sat.w_out, 5);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1));
        settle(); checkField("swap_strobe", bus_sat.wswap_out, 1);

        // Basic MAC with weight 3.
        applyStimulus(mk(0, 0, 0, 0, 3, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, -4, 100, 0, 0, 0, 0));
        settle();
        checkField("mac_sum", bus_sat.sum_out, 88);
        checkField("mac_data", bus_sat.data_out, -4);
        checkField("mac_ovf", bus_sat.ovf_out, 0);

        // Positive overflow: clamp versus wrap, then sticky flag.
        applyStimulus(mk(0, 0, 0, 0, -128, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, -128, 32767, 0, 0, 0, 0));
        settle();
        checkField("sat_sum", bus_sat.sum_out, 32767);
        checkField("sat_ovf", bus_sat.ovf_out, 1);
        checkField("wrap_sum", bus_wrap.sum_out, -16385);
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0));
        settle(); checkField("ovf_sticky", bus_sat.ovf_out, 1);

        // Accumulate, stall, accumulate, then reset between edges.
        applyStimulus(mk(0, 0, 0, 0, 2, 1, 0));
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 1));
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(mk(1, 10, 0, 1, 0, 0, 0));
            settle(); checkField("acc_sum", bus_sat.sum_out, 20 * i);
        end
        applyStimulus(mk(0, 99, 5, 1, 0, 0, 0));
        applyStimulus(mk(0, 99, 5, 1, 0, 0, 0));
        settle();
        checkField("stall_sum", bus_sat.sum_out, 60);
        checkField("stall_data", bus_sat.data_out, 10);
        checkField("stall_active", bus_sat.active_out, 0);
        applyStimulus(mk(1, 10, 0, 1, 0, 0, 0));
        resetPulse();
        applyStimulus(mk(1, 10, 0, 0, 0, 0, 0));
        settle(); checkField("post_reset_sum", bus_sat.sum_out, 0);

        // Simultaneous load and swap while a MAC is in flight.
        applyStimulus(mk(0, 0, 0, 0, 1, 1, 0));
        applyStimulus(mk(0, 0, 0, 0, 4, 1, 1));
        applyStimulus(mk(1, 2, 0, 0, 9, 1, 1));
        settle();
        checkField("collide_sum", bus_sat.sum_out, 2);
        checkField("collide_w_out", bus_sat.w_out, 4);
        applyStimulus(mk(1, 1, 0, 0, 0, 1, 0));
        settle();
        checkField("new_wact_sum", bus_sat.sum_out, 4);
        checkField("new_wsh_w_out", bus_sat.w_out, 9);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                resetPulse();
            end else begin
                s.active = ($urandom_range(0, 3) != 0);
                s.data   = int'($urandom_range(0, 255)) - 128;
                s.sum_in = int'($urandom_range(0, SPAN - 1)) + SMIN;
                s.acc    = $urandom_range(0, 1);
                s.w      = int'($urandom_range(0, 255)) - 128;
                s.wload  = $urandom_range(0, 1);
                s.wswap  = ($urandom_range(0, 3) == 0);
                applyStimulus(s);
            end
        end

        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
        settle();
        settle();
        checkField("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
